fifo_write_arbiter: RTL
=======================

// Module: fifo_write_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one fifo_buffer write port between NUM_REQ producers.
//  Grants one producer at a time and holds the grant for a burst of up to BURST_MAX beats.
//  Forwards the granted producer's data to the FIFO and stalls while the FIFO is full.
//  Sits directly in front of the FIFO's write_e/data_in/full interface.
// PARAMETERS
//  NUM_REQ    4  number of producers (2..8)
//  DATA_W     8  data width; matches the FIFO data_in width
//  BURST_MAX  4  maximum accepted beats per grant (1..16)
// PORTS
//  clk           in   1               rising-edge clock
//  reset         in   1               asynchronous, active-low reset (0 = reset)
//  req           in   NUM_REQ         per-producer write request; data valid while high
//  req_data      in   NUM_REQ*DATA_W  producer i data at [i*DATA_W +: DATA_W]
//  fifo_full     in   1               FIFO full flag
//  gnt           out  NUM_REQ         registered one-hot grant; all zero when idle
//  fifo_write_e  out  1               FIFO write enable (combinational)
//  fifo_data_in  out  DATA_W          FIFO write data (combinational)
//  busy          out  1               registered; 1 while in the BURST state
// BEHAVIOUR
//  - Reset (reset=0, asynchronous): state=IDLE, gnt=0, busy=0, beat_cnt=0, last_owner=NUM_REQ-1.
//    Outputs remain in their reset values until the first clock edge after reset deasserts.
//  - Reset mid-burst: the burst aborts immediately. No beat is written during reset.
//  - Accepted beat: accept = gnt[o] & req[o] & ~fifo_full, where o is the owner.
//    fifo_write_e = accept. fifo_data_in = req_data slice of the owner, or 0 when gnt=0.
//    The FIFO write happens on the same edge (zero added latency).
//  - Producer protocol: hold req and data stable until a beat is accepted. After the edge
//    where gnt[i]&req[i]&~fifo_full, present the next beat or drop req.
//  - Round-robin pick: scan from (last_owner+1) mod NUM_REQ upward with wrap-around.
//    The first asserted req wins. The previous owner has the lowest priority.
//  - FSM IDLE: gnt=0. If |req, pick the winner, load gnt one-hot, set beat_cnt=0 and go to BURST.
//    The first beat can be accepted one cycle after the request.
//  - FSM BURST: on each accept, beat_cnt increments.
//    Release happens when an accept occurs with beat_cnt==BURST_MAX-1, or when req[o]==0.
//  - On release: last_owner=o. Re-pick from the current req in the same cycle.
//    If the winner exists, go to BURST with the new gnt and beat_cnt=0; otherwise go to IDLE with gnt=0.
//    Back-to-back bursts have no idle bubble.
//  - A drop-release writes nothing in that cycle.
//  - The owner's req is eligible at re-pick, but only if no other req is set (fairness).
//  - FIFO full: accept=0, so the beat stalls. beat_cnt and gnt hold; there is no timeout.
//    A stall does not count as a beat.
//  - Simultaneous full and req drop: treated as a release (drop wins); nothing is written.
//  - beat_cnt is $clog2(BURST_MAX+1) bits wide and never exceeds BURST_MAX-1.
//  - gnt is always one-hot or zero. It never points at a producer whose req was low at the pick.
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined: adds outputs stat_beats[15:0] and stat_stalls[15:0] (registered).
//   - stat_beats increments on every accept.
//   - stat_stalls increments on every cycle with gnt[o]&req[o]&fifo_full.
//   - Both wrap modulo 2^16 and clear on reset.
//  FIFO_ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1 Reset: drive reset=0 mid-burst -> gnt=0, busy=0, fifo_write_e=0 immediately.
//    After release, req=4'b0001 -> gnt=0001 after 1 cycle.
//  2 Single producer: req=0001 held with data 0x10..0x15, full=0 -> 4 writes (0x10..0x13).
//    Then a re-grant of 0001 with no idle cycle, then 0x14, 0x15.
//  3 Fairness: req=1111 constant, full=0 -> grant order 0001,0010,0100,1000,0001.
//    Each grant lasts 4 writes; total 16 writes in 16 cycles after the first grant.
//  4 Backpressure: owner 0010 after 2 beats, full=1 for 5 cycles -> fifo_write_e=0 and gnt holds.
//    Then 2 more beats and release; the stall counter (if enabled) reads 5.
//  5 Early drop: owner 0100 drops req after 1 beat, req[0]=1 -> no write that cycle.
//    gnt=0001 on the next cycle.
//  6 Wrap: last_owner=3, req=1001 -> gnt=0001 (scan wraps to 0 before 3).

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter in front of a single FIFO write port.
// Optional FIFO_ARB_STATS_EN adds beat/stall statistics counters.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      fifo_full,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      fifo_write_e,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic                      busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]               stat_beats,
    output logic [15:0]               stat_stalls
`endif
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(BURST_MAX + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     scan_base;
    logic [IW-1:0]     scan_idx;
    logic [IW-1:0]     pick_idx;
    logic              pick_ok;
    logic              own_req;
    logic              accept;
    logic              last_beat;
    logic              rel;

    assign busy         = (state_q == BURST);
    assign own_req      = req[owner_q];
    assign accept       = busy & own_req & ~fifo_full;
    assign last_beat    = (cnt_q == CW'(BURST_MAX - 1));
    assign rel          = busy & (~own_req | (accept & last_beat));
    assign scan_base    = rel ? owner_q : last_q;
    assign fifo_write_e = accept;
    assign fifo_data_in = busy ? req_data[owner_q*DATA_W +: DATA_W] : '0;

    // Scan upward from the entry after the previous owner; it ends on that owner
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx = IW'((int'(scan_base) + i) % NUM_REQ);
            if (!pick_ok && req[scan_idx]) begin
                pick_ok  = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    // Next-state: grant on pick, count beats, re-pick in the release cycle
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    state_d = BURST;
                    gnt_d   = NUM_REQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (rel) begin
                    last_d = owner_q;
                    if (pick_ok) begin
                        gnt_d   = NUM_REQ'(1) << pick_idx;
                        owner_d = pick_idx;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        cnt_d   = '0;
                    end
                end else if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt     <= '0;
            owner_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Accepted-beat and full-stall counters, wrapping at 16 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else begin
            if (accept)
                stat_beats <= stat_beats + 16'd1;
            if (busy & own_req & fifo_full)
                stat_stalls <= stat_stalls + 16'd1;
        end
    end
`endif

endmodule
